// File: rtl/stopwatch_pkg.sv
// Shared stopwatch control codes and button indexing for the button FSM.
// Both the FSM and the stopwatch datapath decode the ST_* codes below.
package stopwatch_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_RESET = 3'b001;
  localparam logic [2:0] ST_COUNT = 3'b010;
  localparam logic [2:0] ST_PAUSE = 3'b011;
  localparam logic [2:0] ST_STOP  = 3'b100;

  localparam int unsigned NumBtn   = 5;
  localparam int unsigned BtnStart = 0;
  localparam int unsigned BtnReset = 1;
  localparam int unsigned BtnCount = 2;
  localparam int unsigned BtnPause = 3;
  localparam int unsigned BtnStop  = 4;

  // At most one press event is acted on per cycle.
  typedef enum logic [2:0] {
    EvNone,
    EvReset,
    EvStop,
    EvPause,
    EvCount
  } btn_event_e;

endpackage

// File: rtl/stopwatch_button_fsm_if.sv
// Board buttons in, stopwatch control code out.
// master: the button FSM (producer); slave: board/datapath side.
interface stopwatch_button_fsm_if;

  logic       ButtonStart;
  logic       ButtonReset;
  logic       ButtonCount;
  logic       ButtonPause;
  logic       ButtonStop;
  logic [2:0] state;
  logic       state_chg;

  modport master (
    input  ButtonStart, ButtonReset, ButtonCount, ButtonPause, ButtonStop,
    output state, state_chg
  );

  modport slave (
    output ButtonStart, ButtonReset, ButtonCount, ButtonPause, ButtonStop,
    input  state, state_chg
  );

endinterface

// File: rtl/button_debounce.sv
// One raw button: polarity fix, 2-flop synchroniser, stable-count debouncer and
// a one-cycle press pulse on the debounced 0->1 edge.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            raw_fix;
  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q;

  assign raw_fix = ACTIVE_LOW ? ~raw_i : raw_i;

  // Count only while the synchronised value disagrees with the debounced level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_fix};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/stopwatch_button_fsm.sv
// Debounced buttons -> stopwatch control code. Define PAUSE_TOGGLE_EN to let a
// Pause press in PAUSE resume counting; otherwise only Count resumes.
module stopwatch_button_fsm
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  stopwatch_button_fsm_if.master sw
);

  logic [NumBtn-1:0] raw, level, press;
  logic [2:0]        state_q, state_d;
  logic              chg_q;
  btn_event_e        ev;
  logic              unused_btn;

  assign raw[BtnStart] = sw.ButtonStart;
  assign raw[BtnReset] = sw.ButtonReset;
  assign raw[BtnCount] = sw.ButtonCount;
  assign raw[BtnPause] = sw.ButtonPause;
  assign raw[BtnStop]  = sw.ButtonStop;

  for (genvar i = 0; i < NumBtn; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (raw[i]),
      .level_o (level[i]),
      .press_o (press[i])
    );
  end

  // Start is a level switch; the push buttons only matter as press events.
  assign unused_btn = ^{press[BtnStart], level[NumBtn-1:1]};

  always_comb begin
    ev = EvNone;
    if      (press[BtnReset]) ev = EvReset;
    else if (press[BtnStop])  ev = EvStop;
    else if (press[BtnPause]) ev = EvPause;
    else if (press[BtnCount]) ev = EvCount;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chg_q   <= (state_d != state_q);
    end
  end

  always_comb begin
    state_d = state_q;
    if (!level[BtnStart]) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_RESET;
        ST_RESET: if (ev == EvCount) state_d = ST_COUNT;
        ST_COUNT: begin
          case (ev)
            EvPause: state_d = ST_PAUSE;
            EvStop:  state_d = ST_STOP;
            EvReset: state_d = ST_RESET;
            default: ;
          endcase
        end
        ST_PAUSE: begin
          case (ev)
            EvCount: state_d = ST_COUNT;
            EvStop:  state_d = ST_STOP;
            EvReset: state_d = ST_RESET;
`ifdef PAUSE_TOGGLE_EN
            EvPause: state_d = ST_COUNT;
`endif
            default: ;
          endcase
        end
        ST_STOP:  if (ev == EvReset) state_d = ST_RESET;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    sw.state     = state_q;
    sw.state_chg = chg_q;
  end

endmodule

// File: tb/tb_stopwatch_button_fsm.sv
// Directed bench for stopwatch_button_fsm with DEBOUNCE_CYCLES=4, active-high buttons.
// Honours PAUSE_TOGGLE_EN when defined for the build.
module tb_stopwatch_button_fsm;
  import stopwatch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   chg_cnt = 0;
  int   c0;

  stopwatch_button_fsm_if sw ();

  stopwatch_button_fsm #(
    .DEBOUNCE_CYCLES (4),
    .BTN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw.master)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sw.state_chg === 1'b1) chg_cnt <= chg_cnt + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: sw.ButtonStart = v;
      1: sw.ButtonReset = v;
      2: sw.ButtonCount = v;
      3: sw.ButtonPause = v;
      default: sw.ButtonStop = v;
    endcase
  endtask

  // Hold a button long enough to register (event lands on the 7th edge), then release it fully.
  task automatic hold_btn(input int b);
    set_btn(b, 1'b1);
    tick(10);
    set_btn(b, 1'b0);
    tick(8);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    sw.ButtonStart = 1'b1;
    sw.ButtonReset = 1'b0;
    sw.ButtonCount = 1'b0;
    sw.ButtonPause = 1'b0;
    sw.ButtonStop  = 1'b0;
    tick(3);
    checks++;
    if (sw.state !== ST_IDLE || sw.state_chg !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %b/%b want 000/0", sw.state, sw.state_chg);
    end
    rst = 1'b0;
    c0 = chg_cnt;
    tick(6);
    checks++;
    if (sw.state !== ST_IDLE) begin
      errors++;
      $display("FAIL start_early got %b want 000", sw.state);
    end
    tick(1);
    checks++;
    if (sw.state !== ST_RESET || sw.state_chg !== 1'b1) begin
      errors++;
      $display("FAIL start_reset got %b/%b want 001/1", sw.state, sw.state_chg);
    end
    tick(3);
    checks++;
    if (chg_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL start_chg_count got %0d want 1", chg_cnt - c0);
    end
  endtask

  task automatic test_count;
    c0 = chg_cnt;
    sw.ButtonCount = 1'b1;
    tick(2);
    sw.ButtonCount = 1'b0;
    tick(4);
    checks++;
    if (sw.state !== ST_RESET) begin
      errors++;
      $display("FAIL glitch_ignored got %b want 001", sw.state);
    end
    sw.ButtonCount = 1'b1;
    tick(6);
    checks++;
    if (sw.state !== ST_RESET) begin
      errors++;
      $display("FAIL count_early got %b want 001", sw.state);
    end
    tick(1);
    checks++;
    if (sw.state !== ST_COUNT || sw.state_chg !== 1'b1) begin
      errors++;
      $display("FAIL count_enter got %b/%b want 010/1", sw.state, sw.state_chg);
    end
    tick(3);
    sw.ButtonCount = 1'b0;
    tick(8);
    checks++;
    if (chg_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL count_chg_count got %0d want 1", chg_cnt - c0);
    end
  endtask

  task automatic test_priority;
    c0 = chg_cnt;
    sw.ButtonPause = 1'b1;
    sw.ButtonStop  = 1'b1;
    tick(7);
    checks++;
    if (sw.state !== ST_STOP || sw.state_chg !== 1'b1) begin
      errors++;
      $display("FAIL stop_over_pause got %b/%b want 100/1", sw.state, sw.state_chg);
    end
    tick(3);
    sw.ButtonPause = 1'b0;
    sw.ButtonStop  = 1'b0;
    tick(8);
    hold_btn(BtnCount);
    checks++;
    if (sw.state !== ST_STOP) begin
      errors++;
      $display("FAIL stop_ignores_count got %b want 100", sw.state);
    end
    sw.ButtonReset = 1'b1;
    tick(7);
    checks++;
    if (sw.state !== ST_RESET || sw.state_chg !== 1'b1) begin
      errors++;
      $display("FAIL stop_to_reset got %b/%b want 001/1", sw.state, sw.state_chg);
    end
    tick(3);
    sw.ButtonReset = 1'b0;
    tick(8);
    checks++;
    if (chg_cnt - c0 !== 2) begin
      errors++;
      $display("FAIL priority_chg_count got %0d want 2", chg_cnt - c0);
    end
  endtask

  task automatic test_pause_toggle;
    logic [2:0] exp_state;
    int         exp_chg;
`ifdef PAUSE_TOGGLE_EN
    exp_state = ST_COUNT;
    exp_chg   = 1;
`else
    exp_state = ST_PAUSE;
    exp_chg   = 0;
`endif
    hold_btn(BtnCount);
    checks++;
    if (sw.state !== ST_COUNT) begin
      errors++;
      $display("FAIL pause_setup_count got %b want 010", sw.state);
    end
    hold_btn(BtnPause);
    checks++;
    if (sw.state !== ST_PAUSE) begin
      errors++;
      $display("FAIL pause_enter got %b want 011", sw.state);
    end
    c0 = chg_cnt;
    sw.ButtonPause = 1'b1;
    tick(7);
    checks++;
    if (sw.state !== exp_state || sw.state_chg !== exp_chg[0]) begin
      errors++;
      $display("FAIL pause_in_pause got %b/%b want %b/%0d", sw.state, sw.state_chg,
               exp_state, exp_chg);
    end
    tick(3);
    sw.ButtonPause = 1'b0;
    tick(8);
    checks++;
    if (chg_cnt - c0 !== exp_chg) begin
      errors++;
      $display("FAIL pause_chg_count got %0d want %0d", chg_cnt - c0, exp_chg);
    end
  endtask

  task automatic test_start_gate;
`ifndef PAUSE_TOGGLE_EN
    hold_btn(BtnCount);
`endif
    checks++;
    if (sw.state !== ST_COUNT) begin
      errors++;
      $display("FAIL gate_setup got %b want 010", sw.state);
    end
    c0 = chg_cnt;
    sw.ButtonStart = 1'b0;
    tick(6);
    checks++;
    if (sw.state !== ST_COUNT) begin
      errors++;
      $display("FAIL gate_early got %b want 010", sw.state);
    end
    tick(1);
    checks++;
    if (sw.state !== ST_IDLE || sw.state_chg !== 1'b1) begin
      errors++;
      $display("FAIL gate_idle got %b/%b want 000/1", sw.state, sw.state_chg);
    end
    tick(3);
    hold_btn(BtnCount);
    checks++;
    if (sw.state !== ST_IDLE) begin
      errors++;
      $display("FAIL gate_count_ignored got %b want 000", sw.state);
    end
    sw.ButtonStart = 1'b1;
    tick(7);
    checks++;
    if (sw.state !== ST_RESET || sw.state_chg !== 1'b1) begin
      errors++;
      $display("FAIL gate_restart got %b/%b want 001/1", sw.state, sw.state_chg);
    end
    tick(3);
    checks++;
    if (chg_cnt - c0 !== 2) begin
      errors++;
      $display("FAIL gate_chg_count got %0d want 2", chg_cnt - c0);
    end
  endtask

  task automatic test_bounce_and_rst;
    c0 = chg_cnt;
    for (int i = 0; i < 10; i++) begin
      sw.ButtonCount = (i % 2 == 0);
      tick(2);
    end
    sw.ButtonCount = 1'b1;
    tick(6);
    checks++;
    if (sw.state !== ST_RESET) begin
      errors++;
      $display("FAIL bounce_early got %b want 001", sw.state);
    end
    tick(1);
    checks++;
    if (sw.state !== ST_COUNT || sw.state_chg !== 1'b1) begin
      errors++;
      $display("FAIL bounce_press got %b/%b want 010/1", sw.state, sw.state_chg);
    end
    tick(3);
    sw.ButtonCount = 1'b0;
    tick(8);
    checks++;
    if (chg_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL bounce_chg_count got %0d want 1", chg_cnt - c0);
    end
    sw.ButtonPause = 1'b1;
    tick(4);
    rst = 1'b1;
    sw.ButtonPause = 1'b0;
    tick(2);
    checks++;
    if (sw.state !== ST_IDLE || sw.state_chg !== 1'b0) begin
      errors++;
      $display("FAIL midcount_rst got %b/%b want 000/0", sw.state, sw.state_chg);
    end
    rst = 1'b0;
    c0 = chg_cnt;
    tick(7);
    checks++;
    if (sw.state !== ST_RESET) begin
      errors++;
      $display("FAIL post_rst_start got %b want 001", sw.state);
    end
    tick(10);
    checks++;
    if (sw.state !== ST_RESET || chg_cnt - c0 !== 1) begin
      errors++;
      $display("FAIL post_rst_no_event got %b/%0d want 001/1", sw.state, chg_cnt - c0);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_priority();
    test_pause_toggle();
    test_start_gate();
    test_bounce_and_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
